// File: rtl/fpu_arb_pkg.sv
// Shared types and defaults for the FPU round-robin arbiter slice.
// Requester-side code can use the fixed-width types when built at default sizes.
package fpu_arb_pkg;

    localparam int unsigned WIDTH_DEF   = 16;
    localparam int unsigned N_REQ_DEF   = 4;
    localparam int unsigned MAX_OUT_DEF = 4;
    localparam int unsigned IDW_DEF     = $clog2(N_REQ_DEF);
    localparam int unsigned CW_DEF      = $clog2(MAX_OUT_DEF + 1);

    typedef logic [IDW_DEF-1:0] req_idx_t;
    typedef logic [CW_DEF-1:0]  credit_t;

    typedef struct packed {
        logic [WIDTH_DEF-1:0] a;
        logic [WIDTH_DEF-1:0] b;
        req_idx_t             tag;
    } issue_t;

    localparam logic [WIDTH_DEF-1:0] OPND_ZERO = '0;

    typedef enum logic {
        SLOT_EMPTY,
        SLOT_FULL
    } slot_state_e;

    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/fpu_rr_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer,
// and moves the pointer past the winner whenever a grant is issued.
module rr_arbiter
    import fpu_arb_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_valid
);

    logic [IW-1:0] ptr_q;

    always_comb begin
        int unsigned k;
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        k         = 0;
        for (int unsigned i = 0; i < N; i++) begin
            k = 32'(ptr_q) + i;
            if (k >= N) begin
                k = k - N;
            end
            if (!gnt_valid && req[k]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IW'(k);
            end
        end
        if (!en) begin
            gnt_valid = 1'b0;
        end
        if (gnt_valid) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (gnt_valid) begin
            ptr_q <= IW'(wrap_inc(32'(gnt_idx), N));
        end
    end

endmodule

// File: rtl/fpu_rr_arbiter.sv
// Shares one fpnew_top between N_REQ requesters: round-robin issue register,
// requester index as FPU tag, tag-routed responses and a global in-flight credit.
module fpu_rr_arbiter
    import fpu_arb_pkg::*;
#(
    parameter  int unsigned WIDTH   = WIDTH_DEF,
    parameter  int unsigned N_REQ   = N_REQ_DEF,
    parameter  int unsigned MAX_OUT = MAX_OUT_DEF,
    localparam int unsigned IDW     = $clog2(N_REQ),
    localparam int unsigned CRW     = $clog2(MAX_OUT + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [N_REQ-1:0]       req_valid_i,
    output logic [N_REQ-1:0]       req_ready_o,
    input  logic [N_REQ*WIDTH-1:0] req_op_a_i,
    input  logic [N_REQ*WIDTH-1:0] req_op_b_i,
    output logic [N_REQ-1:0]       rsp_valid_o,
    input  logic [N_REQ-1:0]       rsp_ready_i,
    output logic [WIDTH-1:0]       rsp_result_o,
    output logic [4:0]             rsp_status_o,
    output logic [3*WIDTH-1:0]     fpu_operands_o,
    output logic                   fpu_in_valid_o,
    input  logic                   fpu_in_ready_i,
    output logic [IDW-1:0]         fpu_tag_o,
    input  logic [WIDTH-1:0]       fpu_result_i,
    input  logic [4:0]             fpu_status_i,
    input  logic [IDW-1:0]         fpu_tag_i,
    input  logic                   fpu_out_valid_i,
    output logic                   fpu_out_ready_o,
    output logic [CRW-1:0]         inflight_o,
    output logic                   err_o
);

    localparam logic [WIDTH-1:0] ZERO_OP = '0;

    slot_state_e      slot_q, slot_d;
    logic [WIDTH-1:0] op_a_q, op_b_q;
    logic [IDW-1:0]   tag_q;
    logic [CRW-1:0]   inflight_q;
    logic             err_q;

    logic             slot_free, credit_ok, arb_en, grant;
    logic             tag_ok, rsp_hs;
    logic [N_REQ-1:0] gnt;
    logic [IDW-1:0]   gnt_idx;

    // Credit check uses the registered count only: a result returning this
    // cycle frees its credit for the next cycle, not this one.
    assign slot_free = (slot_q == SLOT_EMPTY) || fpu_in_ready_i;
    assign credit_ok = inflight_q < CRW'(MAX_OUT);
    assign arb_en    = slot_free && credit_ok;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .req       (req_valid_i),
        .en        (arb_en),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (grant)
    );

    assign req_ready_o = gnt;

    always_comb begin
        slot_d = slot_q;
        if (grant) begin
            slot_d = SLOT_FULL;
        end else if (fpu_in_ready_i) begin
            slot_d = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_q <= SLOT_EMPTY;
            op_a_q <= '0;
            op_b_q <= '0;
            tag_q  <= '0;
        end else begin
            slot_q <= slot_d;
            if (grant) begin
                op_a_q <= req_op_a_i[32'(gnt_idx)*WIDTH +: WIDTH];
                op_b_q <= req_op_b_i[32'(gnt_idx)*WIDTH +: WIDTH];
                tag_q  <= gnt_idx;
            end
        end
    end

    assign fpu_in_valid_o = (slot_q == SLOT_FULL);
    assign fpu_operands_o = {ZERO_OP, op_b_q, op_a_q};
    assign fpu_tag_o      = tag_q;

    // An out-of-range tag has no owner; it is drained (and flagged) rather
    // than left to block the FPU output forever.
    always_comb begin
        tag_ok          = 32'(fpu_tag_i) < N_REQ;
        rsp_valid_o     = '0;
        fpu_out_ready_o = 1'b1;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (fpu_out_valid_i && (32'(fpu_tag_i) == k)) begin
                rsp_valid_o[k] = 1'b1;
            end
        end
        if (tag_ok) begin
            fpu_out_ready_o = rsp_ready_i[fpu_tag_i];
        end
        rsp_hs = fpu_out_valid_i && fpu_out_ready_o;
    end

    assign rsp_result_o = fpu_result_i;
    assign rsp_status_o = fpu_status_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (grant && !rsp_hs) begin
                inflight_q <= inflight_q + 1'b1;
            end else if (!grant && rsp_hs && (inflight_q != '0)) begin
                inflight_q <= inflight_q - 1'b1;
            end
            if (rsp_hs && ((inflight_q == '0) || !tag_ok)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign inflight_o = inflight_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_fpu_rr_arbiter.sv
// Bench for fpu_rr_arbiter: the bench also plays fpnew_top (in-order, ideal latency)
// and keeps a transaction-level model of grants, credits and routed responses.
module tb_fpu_rr_arbiter;

    localparam int unsigned W    = 16;
    localparam int unsigned N    = 4;
    localparam int unsigned MAXO = 4;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  tag;
        logic [4:0]  st;
    } op_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [63:0] op_a, op_b;
    logic [15:0] rsp_result, fpu_result;
    logic [4:0]  rsp_status, fpu_status;
    logic [47:0] fpu_operands;
    logic        fpu_in_valid, fpu_in_ready;
    logic [1:0]  fpu_tag_o, fpu_tag_i;
    logic        fpu_out_valid, fpu_out_ready;
    logic [2:0]  inflight;
    logic        err;

    fpu_rr_arbiter #(.WIDTH(W), .N_REQ(N), .MAX_OUT(MAXO)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_op_a_i      (op_a),
        .req_op_b_i      (op_b),
        .rsp_valid_o     (rsp_valid),
        .rsp_ready_i     (rsp_ready),
        .rsp_result_o    (rsp_result),
        .rsp_status_o    (rsp_status),
        .fpu_operands_o  (fpu_operands),
        .fpu_in_valid_o  (fpu_in_valid),
        .fpu_in_ready_i  (fpu_in_ready),
        .fpu_tag_o       (fpu_tag_o),
        .fpu_result_i    (fpu_result),
        .fpu_status_i    (fpu_status),
        .fpu_tag_i       (fpu_tag_i),
        .fpu_out_valid_i (fpu_out_valid),
        .fpu_out_ready_o (fpu_out_ready),
        .inflight_o      (inflight),
        .err_o           (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    op_t         fq[$];
    int          m_ptr, m_inf, e_g;
    logic        m_iv, m_err;
    logic [15:0] m_a, m_b;
    logic [1:0]  m_tag;
    logic        e_grant, e_acc, e_rsp_hs;
    logic        stray, out_hold, rand_status;
    logic [1:0]  stray_tag;
    logic [3:0]  exp_ready, exp_rsp_valid;
    logic        exp_out_ready;
    logic [15:0] stub_res;
    logic [4:0]  stub_st;

    // Stand-in for the FP16 multiply: exponent addition, exact for powers of two.
    function automatic logic [15:0] fake_mul(input logic [15:0] a, input logic [15:0] b);
        return a + b - 16'h3C00;
    endfunction

    task automatic drive_stub();
        if (fq.size() > 0 && !out_hold) begin
            fpu_out_valid = 1'b1;
            fpu_tag_i     = fq[0].tag;
            stub_res      = fake_mul(fq[0].a, fq[0].b);
            stub_st       = fq[0].st;
        end else if (stray) begin
            fpu_out_valid = 1'b1;
            fpu_tag_i     = stray_tag;
            stub_res      = 16'hDEAD;
            stub_st       = 5'h10;
        end else begin
            fpu_out_valid = 1'b0;
            fpu_tag_i     = 2'd0;
            stub_res      = 16'h0;
            stub_st       = 5'h0;
        end
        fpu_result = stub_res;
        fpu_status = stub_st;
    endtask

    task automatic model_reset();
        fq.delete();
        m_ptr = 0; m_inf = 0; m_iv = 1'b0; m_err = 1'b0;
        m_a = '0; m_b = '0; m_tag = '0;
        stray = 1'b0; out_hold = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0; rsp_ready = '0; fpu_in_ready = 1'b1;
        op_a = '0; op_b = '0;
        model_reset();
        drive_stub();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Expected combinational behaviour for the inputs applied this cycle.
    task automatic prep();
        int  g;
        logic can;
        #1;
        can = (!m_iv || fpu_in_ready) && (m_inf < MAXO);
        g = -1;
        for (int i = 0; i < N; i++) begin
            int k;
            k = (m_ptr + i) % N;
            if (g < 0 && req_valid[k]) g = k;
        end
        e_grant       = can && (g >= 0);
        e_g           = g;
        exp_ready     = e_grant ? 4'(1 << g) : 4'b0;
        exp_rsp_valid = fpu_out_valid ? 4'(1 << fpu_tag_i) : 4'b0;
        exp_out_ready = rsp_ready[fpu_tag_i];
        e_rsp_hs      = fpu_out_valid && exp_out_ready;
        e_acc         = m_iv && fpu_in_ready;
    endtask

    task automatic commit();
        op_t e;
        @(posedge clk);
        if (e_rsp_hs) begin
            if (fq.size() > 0 && !out_hold) void'(fq.pop_front());
            else stray = 1'b0;
            if (m_inf == 0) m_err = 1'b1;
        end
        if (e_acc) begin
            e.a = m_a; e.b = m_b; e.tag = m_tag;
            e.st = rand_status ? 5'($urandom) : 5'h0;
            fq.push_back(e);
        end
        if (e_grant && !e_rsp_hs) m_inf++;
        else if (!e_grant && e_rsp_hs && m_inf > 0) m_inf--;
        if (e_grant) begin
            m_iv  = 1'b1;
            m_a   = op_a[e_g*16 +: 16];
            m_b   = op_b[e_g*16 +: 16];
            m_tag = 2'(e_g);
            m_ptr = (e_g + 1) % N;
        end else if (fpu_in_ready) begin
            m_iv = 1'b0;
        end
        @(negedge clk);
        drive_stub();
    endtask

    task automatic drain();
        int c;
        req_valid = '0; rsp_ready = '1; fpu_in_ready = 1'b1; out_hold = 1'b0;
        c = 0;
        while (!(m_inf == 0 && !m_iv && fq.size() == 0) && c < 50) begin
            prep(); commit(); c++;
        end
        prep();
        n_cmp++;
        if (c >= 50 || inflight !== 3'd0) begin
            n_bad++;
            $display("FAIL drain: inflight %0d model %0d cycles %0d", inflight, m_inf, c);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '0; rsp_ready = '0; fpu_in_ready = 1'b1; op_a = '0; op_b = '0;
        model_reset(); drive_stub();
        @(negedge clk);
        n_cmp++;
        if ({fpu_in_valid, fpu_operands, fpu_tag_o, inflight, err} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: valid %b ops %h tag %0d infl %0d err %b (want all 0)",
                     fpu_in_valid, fpu_operands, fpu_tag_o, inflight, err);
        end
        rst_n = 1'b1;
        prep();
        n_cmp++;
        if (req_ready !== 4'b0 || rsp_valid !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_idle: ready %b rsp_valid %b want 0000/0000", req_ready, rsp_valid);
        end
        commit();
    endtask

    task automatic test_single();
        int pulses, seen, maxinf;
        do_reset();
        rand_status = 1'b0;
        rsp_ready = '1;
        op_a[15:0] = 16'h3C00; op_b[15:0] = 16'h4000;
        req_valid = 4'b0001;
        pulses = 0; seen = 0; maxinf = 0;
        for (int c = 0; c < 12; c++) begin
            prep();
            n_cmp++;
            if (req_ready !== exp_ready) begin
                n_bad++; $display("FAIL single_ready c%0d: got %b want %b", c, req_ready, exp_ready);
            end
            if (req_ready[0]) pulses++;
            n_cmp++;
            if (fpu_in_valid !== m_iv || fpu_operands !== {16'h0, m_b, m_a} || fpu_tag_o !== m_tag) begin
                n_bad++; $display("FAIL single_issue c%0d: v%b ops %h tag %0d want v%b ops %h tag %0d",
                                  c, fpu_in_valid, fpu_operands, fpu_tag_o, m_iv, {16'h0, m_b, m_a}, m_tag);
            end
            n_cmp++;
            if (rsp_valid !== exp_rsp_valid) begin
                n_bad++; $display("FAIL single_rsp_valid c%0d: got %b want %b", c, rsp_valid, exp_rsp_valid);
            end
            if (rsp_valid[0]) begin
                seen++;
                n_cmp++;
                if (rsp_result !== 16'h4000 || rsp_status !== 5'h0) begin
                    n_bad++; $display("FAIL single_result: got %h/%h want 4000/00", rsp_result, rsp_status);
                end
            end
            n_cmp++;
            if (inflight !== 3'(m_inf)) begin
                n_bad++; $display("FAIL single_inflight c%0d: got %0d want %0d", c, inflight, m_inf);
            end
            if (int'(inflight) > maxinf) maxinf = int'(inflight);
            commit();
            if (e_grant) req_valid = '0;
        end
        n_cmp++;
        if (pulses != 1 || seen != 1 || maxinf != 1 || inflight !== 3'd0) begin
            n_bad++; $display("FAIL single_totals: pulses %0d rsp %0d maxinf %0d infl %0d want 1 1 1 0",
                              pulses, seen, maxinf, inflight);
        end
    endtask

    task automatic test_round_robin();
        int cnt[4];
        int n_rsp;
        do_reset();
        rand_status = 1'b1;
        rsp_ready = '1; req_valid = '1;
        cnt = '{default: 0}; n_rsp = 0;
        for (int c = 0; c < 40; c++) begin
            op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom};
            prep();
            n_cmp++;
            if (req_ready !== 4'(1 << (c % 4))) begin
                n_bad++; $display("FAIL rr_order c%0d: got %b want %b", c, req_ready, 4'(1 << (c % 4)));
            end
            for (int k = 0; k < 4; k++) if (req_ready[k]) cnt[k]++;
            if (c > 0) begin
                n_cmp++;
                if (fpu_tag_o !== 2'((c - 1) % 4) || fpu_in_valid !== 1'b1) begin
                    n_bad++; $display("FAIL rr_tag c%0d: got %0d v%b want %0d v1", c, fpu_tag_o, fpu_in_valid, (c - 1) % 4);
                end
            end
            if (fpu_out_valid) begin
                n_cmp++;
                if (rsp_valid !== 4'(1 << (n_rsp % 4)) || rsp_result !== stub_res || rsp_status !== stub_st) begin
                    n_bad++; $display("FAIL rr_rsp #%0d: valid %b res %h st %h want %b %h %h",
                                      n_rsp, rsp_valid, rsp_result, rsp_status, 4'(1 << (n_rsp % 4)), stub_res, stub_st);
                end
                n_rsp++;
            end
            commit();
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (cnt[k] != 10) begin
                n_bad++; $display("FAIL rr_share req%0d: got %0d grants want 10", k, cnt[k]);
            end
        end
        n_cmp++;
        if (n_rsp < 36) begin
            n_bad++; $display("FAIL rr_rsp_count: got %0d want >=36", n_rsp);
        end
        drain();
    endtask

    task automatic test_credit();
        int grants;
        do_reset();
        req_valid = '1; rsp_ready = '0; fpu_in_ready = 1'b1;
        grants = 0;
        for (int c = 0; c < 8; c++) begin
            prep();
            n_cmp++;
            if (req_ready !== exp_ready) begin
                n_bad++; $display("FAIL credit_ready c%0d: got %b want %b", c, req_ready, exp_ready);
            end
            if (req_ready != 4'b0) grants++;
            commit();
        end
        n_cmp++;
        if (grants != 4 || inflight !== 3'd4) begin
            n_bad++; $display("FAIL credit_limit: grants %0d infl %0d want 4 4", grants, inflight);
        end
        rsp_ready = '1;
        prep();
        n_cmp++;
        if (req_ready !== 4'b0 || fpu_out_ready !== 1'b1 || rsp_valid !== 4'b0001) begin
            n_bad++; $display("FAIL credit_no_reuse: ready %b out_ready %b rsp %b want 0000 1 0001",
                              req_ready, fpu_out_ready, rsp_valid);
        end
        commit();
        rsp_ready = '0;
        prep();
        n_cmp++;
        if (req_ready !== 4'b0001 || inflight !== 3'd3) begin
            n_bad++; $display("FAIL credit_regrant: ready %b infl %0d want 0001 3", req_ready, inflight);
        end
        commit();
        drain();
    endtask

    task automatic test_in_stall();
        logic [15:0] a0, b0, a1, b1;
        do_reset();
        a0 = 16'($urandom); b0 = 16'($urandom); a1 = 16'($urandom); b1 = 16'($urandom);
        op_a = {32'h0, a1, a0}; op_b = {32'h0, b1, b0};
        rsp_ready = '1; req_valid = 4'b0001;
        prep();
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_bad++; $display("FAIL stall_first: got %b want 0001", req_ready);
        end
        commit();
        req_valid = 4'b0010; fpu_in_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            prep();
            n_cmp++;
            if (fpu_in_valid !== 1'b1 || fpu_operands !== {16'h0, b0, a0} || fpu_tag_o !== 2'd0 || req_ready !== 4'b0) begin
                n_bad++; $display("FAIL stall_hold c%0d: v%b ops %h tag %0d ready %b want 1 %h 0 0000",
                                  c, fpu_in_valid, fpu_operands, fpu_tag_o, req_ready, {16'h0, b0, a0});
            end
            commit();
        end
        fpu_in_ready = 1'b1;
        prep();
        n_cmp++;
        if (req_ready !== 4'b0010) begin
            n_bad++; $display("FAIL stall_b2b_grant: got %b want 0010", req_ready);
        end
        commit();
        req_valid = '0;
        prep();
        n_cmp++;
        if (fpu_in_valid !== 1'b1 || fpu_operands !== {16'h0, b1, a1} || fpu_tag_o !== 2'd1) begin
            n_bad++; $display("FAIL stall_b2b_payload: v%b ops %h tag %0d want 1 %h 1",
                              fpu_in_valid, fpu_operands, fpu_tag_o, {16'h0, b1, a1});
        end
        commit();
        drain();
    endtask

    task automatic test_out_stall();
        do_reset();
        req_valid = 4'b0100; rsp_ready = 4'b1011;
        prep(); commit();
        req_valid = '0;
        for (int c = 0; c < 10 && !fpu_out_valid; c++) begin
            prep(); commit();
        end
        n_cmp++;
        if (!fpu_out_valid) begin
            n_bad++; $display("FAIL out_stall_timeout: no tag-2 result within 10 cycles");
        end
        for (int c = 0; c < 3; c++) begin
            prep();
            n_cmp++;
            if (fpu_out_ready !== 1'b0 || rsp_valid !== 4'b0100 || inflight !== 3'd1) begin
                n_bad++; $display("FAIL out_stall c%0d: out_ready %b rsp %b infl %0d want 0 0100 1",
                                  c, fpu_out_ready, rsp_valid, inflight);
            end
            commit();
        end
        drain();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_valid = '1; rsp_ready = '0;
        for (int c = 0; c < 3; c++) begin
            op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom};
            prep(); commit();
        end
        n_cmp++;
        if (inflight !== 3'd3 || fpu_in_valid !== 1'b1) begin
            n_bad++; $display("FAIL mid_pre: infl %0d v%b want 3 1", inflight, fpu_in_valid);
        end
        #2;
        rst_n = 1'b0;
        req_valid = '0;
        model_reset(); drive_stub();
        #1;
        n_cmp++;
        if ({fpu_in_valid, fpu_operands, fpu_tag_o, inflight, err} !== '0) begin
            n_bad++; $display("FAIL mid_async: v%b ops %h tag %0d infl %0d err %b want all 0",
                              fpu_in_valid, fpu_operands, fpu_tag_o, inflight, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        prep();
        n_cmp++;
        if (err !== 1'b0 || inflight !== 3'd0 || rsp_valid !== 4'b0) begin
            n_bad++; $display("FAIL mid_after: err %b infl %0d rsp %b want 0 0 0000", err, inflight, rsp_valid);
        end
        commit();
    endtask

    task automatic test_error();
        do_reset();
        rsp_ready = '1; stray = 1'b1; stray_tag = 2'd1;
        drive_stub();
        prep();
        n_cmp++;
        if (rsp_valid !== 4'b0010 || fpu_out_ready !== 1'b1 || err !== 1'b0) begin
            n_bad++; $display("FAIL err_stray_rsp: rsp %b out_ready %b err %b want 0010 1 0",
                              rsp_valid, fpu_out_ready, err);
        end
        commit();
        prep();
        n_cmp++;
        if (err !== 1'b1 || inflight !== 3'd0) begin
            n_bad++; $display("FAIL err_set: err %b infl %0d want 1 0", err, inflight);
        end
        commit();
        req_valid = 4'b1000;
        prep(); commit();
        req_valid = '0;
        for (int c = 0; c < 4; c++) begin
            prep();
            n_cmp++;
            if (err !== 1'b1 || inflight !== 3'(m_inf)) begin
                n_bad++; $display("FAIL err_sticky c%0d: err %b infl %0d want 1 %0d", c, err, inflight, m_inf);
            end
            commit();
        end
        do_reset();
        #1;
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++; $display("FAIL err_clear: got %b want 0", err);
        end
    endtask

    task automatic test_random();
        do_reset();
        rand_status = 1'b1;
        for (int c = 0; c < 300; c++) begin
            req_valid    = 4'($urandom);
            op_a         = {$urandom, $urandom};
            op_b         = {$urandom, $urandom};
            fpu_in_ready = ($urandom_range(3) != 0);
            rsp_ready    = 4'($urandom) | 4'($urandom);
            prep();
            n_cmp++;
            if (req_ready !== exp_ready) begin
                n_bad++; $display("FAIL rnd_ready c%0d: got %b want %b", c, req_ready, exp_ready);
            end
            n_cmp++;
            if (rsp_valid !== exp_rsp_valid || fpu_out_ready !== exp_out_ready) begin
                n_bad++; $display("FAIL rnd_rsp c%0d: valid %b ordy %b want %b %b",
                                  c, rsp_valid, fpu_out_ready, exp_rsp_valid, exp_out_ready);
            end
            n_cmp++;
            if (fpu_in_valid !== m_iv || fpu_operands !== {16'h0, m_b, m_a} || fpu_tag_o !== m_tag) begin
                n_bad++; $display("FAIL rnd_issue c%0d: v%b ops %h tag %0d want v%b %h %0d",
                                  c, fpu_in_valid, fpu_operands, fpu_tag_o, m_iv, {16'h0, m_b, m_a}, m_tag);
            end
            n_cmp++;
            if (inflight !== 3'(m_inf) || err !== m_err) begin
                n_bad++; $display("FAIL rnd_credit c%0d: infl %0d err %b want %0d %b", c, inflight, err, m_inf, m_err);
            end
            if (fpu_out_valid) begin
                n_cmp++;
                if (rsp_result !== stub_res || rsp_status !== stub_st) begin
                    n_bad++; $display("FAIL rnd_data c%0d: got %h/%h want %h/%h", c, rsp_result, rsp_status, stub_res, stub_st);
                end
            end
            out_hold = ($urandom_range(3) == 0);
            commit();
        end
        drain();
    endtask

    initial begin
        req_valid = '0; rsp_ready = '0; fpu_in_ready = 1'b1; op_a = '0; op_b = '0;
        rand_status = 1'b0; stray_tag = 2'd0;
        model_reset(); drive_stub();
        test_reset();
        test_single();
        test_round_robin();
        test_credit();
        test_in_stall();
        test_out_stall();
        test_reset_mid();
        test_error();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
